usrt_rx: RTL and testbench

Parametrised USRT receive path that replaces the fixed 8-bit deserializer. It sits between the serial `Tx` line and the AMBA read side. It samples frames on a baud strobe from `baud_gen`, with configurable data width, parity mode and stop-bit count. Good frames are buffered in a small FIFO; bad or overrunning frames are dropped with distinct error pulses and sticky flags.

---
 rtl/usrt_pkg.sv | 21 ++
 rtl/usrt_rx_fifo.sv | 48 ++++
 rtl/usrt_rx.sv | 172 +++++++++++++++++
 tb/tb_usrt_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usrt_pkg.sv
// Shared constants and types for the USRT receive path.
package usrt_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    RESYNC = 3'd4
  } rx_state_e;

  // Bit positions inside errFlags = {ovr, frm, par}
  localparam int ERR_PAR = 0;
  localparam int ERR_FRM = 1;
  localparam int ERR_OVR = 2;

endpackage

// File: rtl/usrt_rx_fifo.sv
// Receive FIFO: power-of-two depth, combinational head read, push accepted
// when full only if a pop happens in the same cycle.
module usrt_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/usrt_rx.sv
// USRT receiver: frame FSM, deserializer, parity check, error flags, FIFO.
// Define USRT_RX_SYNC_EN to pass Tx through a 2-flop synchronizer.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (Tx=0 on bitEn)
// DATA   | shifting in DATA_W data bits, LSB first
// PARITY | checking the parity bit against the accumulator
// STOP   | checking stop bits; last good one pushes or reports
// RESYNC | after a framing error, wait for the line to go high
module usrt_rx
  import usrt_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                         pClk,
  input  logic                         pReset,
  input  logic                         bitEn,
  input  logic                         rxEn,
  input  logic                         Tx,
  input  logic                         rReady,
  output logic [DATA_W-1:0]            rData,
  output logic                         rValid,
  output logic [$clog2(FIFO_DEPTH):0]  fifoCnt,
  output logic                         parErr,
  output logic                         frmErr,
  output logic                         ovrErr,
  input  logic                         errClr,
  output logic [2:0]                   errFlags
);

  localparam int CNT_W = $clog2(DATA_W);

  logic rx;

`ifdef USRT_RX_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) sync <= 2'b11;
    else        sync <= {sync[0], Tx};
  end
  assign rx = sync[1];
`else
  assign rx = Tx;
`endif

  rx_state_e         state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              acc, acc_nxt;
  logic              par_bad, par_bad_nxt;
  logic              stop_cnt, stop_cnt_nxt;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              par_exp;
  logic [2:0]        err_set;

  assign pop     = rValid && rReady;
  assign rValid  = !empty;
  assign par_exp = (PARITY_MODE == PAR_ODD) ? ~acc : acc;

  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      acc      <= 1'b0;
      par_bad  <= 1'b0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      acc      <= acc_nxt;
      par_bad  <= par_bad_nxt;
      stop_cnt <= stop_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    acc_nxt      = acc;
    par_bad_nxt  = par_bad;
    stop_cnt_nxt = stop_cnt;
    push         = 1'b0;
    parErr       = 1'b0;
    frmErr       = 1'b0;
    ovrErr       = 1'b0;

    // Disabling the receiver drops any partial frame without reporting it
    if (!rxEn) begin
      state_nxt = IDLE;
    end else if (bitEn) begin
      case (state)
        IDLE: begin
          if (!rx) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
            acc_nxt     = 1'b0;
            par_bad_nxt = 1'b0;
          end
        end
        DATA: begin
          shreg_nxt = {rx, shreg[DATA_W-1:1]};
          acc_nxt   = acc ^ rx;
          if (bit_cnt == CNT_W'(DATA_W-1)) begin
            stop_cnt_nxt = 1'b0;
            state_nxt    = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          par_bad_nxt = (rx != par_exp);
          state_nxt   = STOP;
        end
        STOP: begin
          if (!rx) begin
            frmErr    = 1'b1;
            state_nxt = RESYNC;
          end else if (stop_cnt == 1'(STOP_BITS-1)) begin
            if (par_bad)           parErr = 1'b1;
            else if (full && !pop) ovrErr = 1'b1;
            else                   push   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_cnt_nxt = stop_cnt + 1'b1;
          end
        end
        RESYNC: begin
          if (rx) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    err_set          = 3'b000;
    err_set[ERR_PAR] = parErr;
    err_set[ERR_FRM] = frmErr;
    err_set[ERR_OVR] = ovrErr;
  end

  // A new error in the clearing cycle survives the clear
  always_ff @(posedge pClk or posedge pReset) begin
    if (pReset) errFlags <= 3'b000;
    else        errFlags <= (errFlags & {3{~errClr}}) | err_set;
  end

  usrt_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (pClk),
    .rst       (pReset),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .head      (rData),
    .full      (full),
    .empty     (empty),
    .count     (fifoCnt)
  );

endmodule

// File: tb/tb_usrt_rx.sv
// Directed bench for usrt_rx: default instance plus a 5-bit/odd/2-stop instance.
module tb_usrt_rx;

  logic pClk = 1'b0;
  logic pReset, bitEn, rxEn, tx_a, tx_b, rReady, errClr;

  logic [7:0] rdata_a;
  logic       rvalid_a, par_a, frm_a, ovr_a;
  logic [2:0] cnt_a, flags_a;
  logic [4:0] rdata_b;
  logic       rvalid_b, par_b, frm_b, ovr_b;
  logic [2:0] cnt_b, flags_b;

  int total = 0;
  int bad   = 0;
  int npar_a = 0, nfrm_a = 0, novr_a = 0;
  int npar_b = 0, nfrm_b = 0, novr_b = 0;
  logic rv_snap_a, rv_snap_b;

  always #5 pClk = ~pClk;

  usrt_rx #(.DATA_W(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .pClk(pClk), .pReset(pReset), .bitEn(bitEn), .rxEn(rxEn), .Tx(tx_a),
    .rReady(rReady), .rData(rdata_a), .rValid(rvalid_a), .fifoCnt(cnt_a),
    .parErr(par_a), .frmErr(frm_a), .ovrErr(ovr_a), .errClr(errClr),
    .errFlags(flags_a));

  usrt_rx #(.DATA_W(5), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .pClk(pClk), .pReset(pReset), .bitEn(bitEn), .rxEn(rxEn), .Tx(tx_b),
    .rReady(rReady), .rData(rdata_b), .rValid(rvalid_b), .fifoCnt(cnt_b),
    .parErr(par_b), .frmErr(frm_b), .ovrErr(ovr_b), .errClr(errClr),
    .errFlags(flags_b));

  always @(negedge pClk) begin
    if (par_a) npar_a++;
    if (frm_a) nfrm_a++;
    if (ovr_a) novr_a++;
    if (par_b) npar_b++;
    if (frm_b) nfrm_b++;
    if (ovr_b) novr_b++;
  end

  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  // One bit period: line set, three quiet cycles, then one strobe cycle.
  task automatic send_bit(input bit which, input logic b, input bit pop);
    if (which) tx_b = b; else tx_a = b;
    bitEn = 1'b0;
    repeat (3) tick();
    bitEn  = 1'b1;
    rReady = pop;
    @(negedge pClk);
    rv_snap_a = rvalid_a;
    rv_snap_b = rvalid_b;
    @(posedge pClk);
    #1;
    bitEn  = 1'b0;
    rReady = 1'b0;
  endtask

  // 8-bit even-parity frame on instance A
  task automatic send_a(input logic [7:0] d, input logic flip_par,
                        input logic stopv, input bit pop_end);
    send_bit(0, 1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(0, d[i], 0);
    send_bit(0, (^d) ^ flip_par, 0);
    send_bit(0, stopv, pop_end);
  endtask

  task automatic pop_one();
    rReady = 1'b1;
    tick();
    rReady = 1'b0;
  endtask

  task automatic clear_flags();
    errClr = 1'b1;
    tick();
    errClr = 1'b0;
  endtask

  task automatic test_reset();
    pReset = 1'b1; bitEn = 1'b0; rxEn = 1'b1; tx_a = 1'b1; tx_b = 1'b1;
    rReady = 1'b0; errClr = 1'b0;
    repeat (3) tick();
    pReset = 1'b0;
    tick();
    total++; if (rvalid_a !== 1'b0) begin $display("FAIL reset_rvalid got %b want 0", rvalid_a); bad++; end
    total++; if (cnt_a !== 3'd0) begin $display("FAIL reset_cnt got %0d want 0", cnt_a); bad++; end
    total++; if (rdata_a !== 8'h00) begin $display("FAIL reset_rdata got %h want 00", rdata_a); bad++; end
    total++; if (flags_a !== 3'b000) begin $display("FAIL reset_flags got %b want 000", flags_a); bad++; end
    total++; if ({par_a, frm_a, ovr_a} !== 3'b000) begin $display("FAIL reset_pulses got %b want 000", {par_a, frm_a, ovr_a}); bad++; end
    total++; if ({rvalid_b, cnt_b} !== 4'b0000) begin $display("FAIL reset_b got %b want 0000", {rvalid_b, cnt_b}); bad++; end
  endtask

  task automatic test_good_frame();
    int p0, f0, o0;
    p0 = npar_a; f0 = nfrm_a; o0 = novr_a;
    send_a(8'hA5, 1'b0, 1'b1, 0);
    total++; if (rv_snap_a !== 1'b0) begin $display("FAIL good_latency rvalid in push cycle got %b want 0", rv_snap_a); bad++; end
    total++; if (rvalid_a !== 1'b1) begin $display("FAIL good_rvalid got %b want 1", rvalid_a); bad++; end
    total++; if (rdata_a !== 8'hA5) begin $display("FAIL good_rdata got %h want a5", rdata_a); bad++; end
    total++; if (cnt_a !== 3'd1) begin $display("FAIL good_cnt got %0d want 1", cnt_a); bad++; end
    total++; if ((npar_a - p0) + (nfrm_a - f0) + (novr_a - o0) !== 0) begin $display("FAIL good_no_err got %0d want 0", (npar_a - p0) + (nfrm_a - f0) + (novr_a - o0)); bad++; end
    pop_one();
    total++; if ({rvalid_a, cnt_a} !== 4'b0000) begin $display("FAIL good_pop got %b want 0000", {rvalid_a, cnt_a}); bad++; end
  endtask

  task automatic test_parity();
    int p0;
    p0 = npar_a;
    send_a(8'h3C, 1'b1, 1'b1, 0);
    total++; if (npar_a - p0 !== 1) begin $display("FAIL par_pulse got %0d want 1", npar_a - p0); bad++; end
    total++; if (flags_a !== 3'b001) begin $display("FAIL par_flags got %b want 001", flags_a); bad++; end
    total++; if (cnt_a !== 3'd0) begin $display("FAIL par_cnt got %0d want 0", cnt_a); bad++; end
    clear_flags();
    total++; if (flags_a !== 3'b000) begin $display("FAIL par_clr got %b want 000", flags_a); bad++; end
  endtask

  task automatic test_framing();
    int f0;
    f0 = nfrm_a;
    send_a(8'h55, 1'b0, 1'b0, 0);
    repeat (5) send_bit(0, 1'b0, 0);
    total++; if (nfrm_a - f0 !== 1) begin $display("FAIL frm_pulse got %0d want 1", nfrm_a - f0); bad++; end
    total++; if (cnt_a !== 3'd0) begin $display("FAIL frm_nopush got %0d want 0", cnt_a); bad++; end
    total++; if (flags_a !== 3'b010) begin $display("FAIL frm_flags got %b want 010", flags_a); bad++; end
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b1, 0);
    send_a(8'h12, 1'b0, 1'b1, 0);
    total++; if (rdata_a !== 8'h12 || cnt_a !== 3'd1) begin $display("FAIL frm_recover got %h/%0d want 12/1", rdata_a, cnt_a); bad++; end
    total++; if (nfrm_a - f0 !== 1) begin $display("FAIL frm_once got %0d want 1", nfrm_a - f0); bad++; end
    pop_one();
    clear_flags();
  endtask

  task automatic test_overrun();
    logic [7:0] exp_a [4];
    int o0;
    o0 = novr_a;
    for (int i = 1; i <= 4; i++) send_a(8'(i), 1'b0, 1'b1, 0);
    total++; if (cnt_a !== 3'd4) begin $display("FAIL ovr_fill got %0d want 4", cnt_a); bad++; end
    send_a(8'h77, 1'b0, 1'b1, 0);
    total++; if (novr_a - o0 !== 1) begin $display("FAIL ovr_pulse got %0d want 1", novr_a - o0); bad++; end
    total++; if (cnt_a !== 3'd4) begin $display("FAIL ovr_cnt got %0d want 4", cnt_a); bad++; end
    total++; if (flags_a !== 3'b100) begin $display("FAIL ovr_flags got %b want 100", flags_a); bad++; end
    for (int i = 1; i <= 4; i++) begin
      total++; if (rdata_a !== 8'(i)) begin $display("FAIL ovr_order[%0d] got %h want %h", i, rdata_a, 8'(i)); bad++; end
      pop_one();
    end
    clear_flags();
    o0 = novr_a;
    for (int i = 1; i <= 4; i++) send_a(8'(i), 1'b0, 1'b1, 0);
    send_a(8'h77, 1'b0, 1'b1, 1);
    total++; if (novr_a - o0 !== 0) begin $display("FAIL ovr_poppush_pulse got %0d want 0", novr_a - o0); bad++; end
    total++; if (cnt_a !== 3'd4) begin $display("FAIL ovr_poppush_cnt got %0d want 4", cnt_a); bad++; end
    exp_a[0] = 8'h02; exp_a[1] = 8'h03; exp_a[2] = 8'h04; exp_a[3] = 8'h77;
    for (int i = 0; i < 4; i++) begin
      total++; if (rdata_a !== exp_a[i]) begin $display("FAIL ovr_poppush_order[%0d] got %h want %h", i, rdata_a, exp_a[i]); bad++; end
      pop_one();
    end
  endtask

  task automatic test_rxen_abort();
    int e0;
    e0 = npar_a + nfrm_a + novr_a;
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b1, 0);
    rxEn = 1'b0;
    send_bit(0, 1'b0, 0);
    tx_a = 1'b1;
    tick();
    rxEn = 1'b1;
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b1, 0);
    total++; if (cnt_a !== 3'd0 || npar_a + nfrm_a + novr_a !== e0) begin $display("FAIL abort_silent got cnt=%0d errs=%0d want 0/0", cnt_a, npar_a + nfrm_a + novr_a - e0); bad++; end
    send_a(8'h9E, 1'b0, 1'b1, 0);
    total++; if (rdata_a !== 8'h9E || cnt_a !== 3'd1) begin $display("FAIL abort_next got %h/%0d want 9e/1", rdata_a, cnt_a); bad++; end
    pop_one();
  endtask

  task automatic test_cfg_b();
    logic [4:0] d;
    int p0;
    d  = 5'h1F;
    p0 = npar_b;
    send_bit(1, 1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1, d[i], 0);
    send_bit(1, 1'b0, 0);
    send_bit(1, 1'b1, 0);
    total++; if (cnt_b !== 3'd0) begin $display("FAIL b_stop1 got %0d want 0", cnt_b); bad++; end
    send_bit(1, 1'b1, 0);
    total++; if (cnt_b !== 3'd1 || rdata_b !== 5'h1F) begin $display("FAIL b_stop2 got %0d/%h want 1/1f", cnt_b, rdata_b); bad++; end
    total++; if (npar_b - p0 !== 0) begin $display("FAIL b_par_ok got %0d want 0", npar_b - p0); bad++; end
    pop_one();
    send_bit(1, 1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1, d[i], 0);
    send_bit(1, 1'b1, 0);
    send_bit(1, 1'b1, 0);
    send_bit(1, 1'b1, 0);
    total++; if (npar_b - p0 !== 1 || cnt_b !== 3'd0) begin $display("FAIL b_par_bad got %0d/%0d want 1/0", npar_b - p0, cnt_b); bad++; end
    total++; if (flags_b !== 3'b001) begin $display("FAIL b_flags got %b want 001", flags_b); bad++; end
  endtask

  task automatic test_reset_mid();
    int p0;
    send_a(8'h3C, 1'b1, 1'b1, 0);
    send_a(8'h66, 1'b0, 1'b1, 0);
    send_bit(0, 1'b0, 0);
    send_bit(0, 1'b1, 0);
    send_bit(0, 1'b1, 0);
    #3 pReset = 1'b1;
    #1;
    total++; if ({rvalid_a, cnt_a, flags_a} !== 7'd0) begin $display("FAIL rst_mid_a got %b want 0000000", {rvalid_a, cnt_a, flags_a}); bad++; end
    total++; if (rdata_a !== 8'h00) begin $display("FAIL rst_mid_rdata got %h want 00", rdata_a); bad++; end
    total++; if ({rvalid_b, cnt_b, flags_b} !== 7'd0) begin $display("FAIL rst_mid_b got %b want 0000000", {rvalid_b, cnt_b, flags_b}); bad++; end
    tx_a = 1'b1;
    tick();
    tick();
    pReset = 1'b0;
    tick();
    p0 = npar_a;
    send_a(8'h5A, 1'b0, 1'b1, 0);
    total++; if (rdata_a !== 8'h5A || cnt_a !== 3'd1 || npar_a != p0) begin $display("FAIL rst_mid_after got %h/%0d want 5a/1", rdata_a, cnt_a); bad++; end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity();
    test_framing();
    test_overrun();
    test_rxen_abort();
    test_cfg_b();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
